// File: rtl/aes_ip_pkg.sv
// rtl/aes_ip_pkg.sv - shared types, sizes and block packing helper for the AES IP
package aes_ip_pkg;

    typedef enum logic [2:0] {
        IDLE,
        FETCH,
        WAIT,
        OUT,
        DONE
    } rd_state_t;

    localparam int WORDS_PER_BLK = 4;
    localparam int BLK_W         = 128;
    localparam int WORD_W        = 32;

    // Slot 0 is the most significant word so the lowest address lands in [127:96].
    function automatic logic [BLK_W-1:0] place_word(
        input logic [BLK_W-1:0]  blk,
        input logic [1:0]        slot,
        input logic [WORD_W-1:0] word
    );
        logic [BLK_W-1:0] r;
        r = blk;
        case (slot)
            2'd0:    r[127:96] = word;
            2'd1:    r[95:64]  = word;
            2'd2:    r[63:32]  = word;
            default: r[31:0]   = word;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/data_bram_reader_if.sv
// rtl/data_bram_reader_if.sv - BRAM read port plus block valid/ready handshake
interface data_bram_reader_if
    import aes_ip_pkg::*;
#(
    parameter int ADDR_W = 9
);
    logic              bramEn;
    logic [ADDR_W-1:0] bramAddr;
    logic [WORD_W-1:0] bramDout;
    logic [BLK_W-1:0]  blkData;
    logic              blkValid;
    logic              blkReady;
    logic              blkLast;

    modport master (
        output bramEn, bramAddr, blkData, blkValid, blkLast,
        input  bramDout, blkReady
    );

    modport slave (
        input  bramEn, bramAddr, blkData, blkValid, blkLast,
        output bramDout, blkReady
    );
endinterface

// File: rtl/data_bram_reader.sv
// rtl/data_bram_reader.sv - fetches NDATA BRAM words and emits them as 128-bit blocks
module data_bram_reader
    import aes_ip_pkg::*;
#(
    parameter int NDATA  = 17,
    parameter int ADDR_W = 9
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    output logic               busy,
    output logic               done,
    data_bram_reader_if.master bus
);

    localparam logic [ADDR_W:0] LAST_CNT = (ADDR_W + 1)'(NDATA);
    localparam logic [2:0]      BLK_CNT  = 3'(WORDS_PER_BLK);

    rd_state_t       state;
    logic [ADDR_W:0] cnt;
    logic [2:0]      issued;
    logic [1:0]      slot;
    logic            rd_pend;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state        <= IDLE;
            cnt          <= '0;
            issued       <= '0;
            slot         <= '0;
            rd_pend      <= 1'b0;
            busy         <= 1'b0;
            done         <= 1'b0;
            bus.bramEn   <= 1'b0;
            bus.bramAddr <= '0;
            bus.blkData  <= '0;
            bus.blkValid <= 1'b0;
            bus.blkLast  <= 1'b0;
        end else begin
            // rd_pend marks the edge on which the previous cycle's read data is valid
            rd_pend <= bus.bramEn;
            case (state)
                IDLE: begin
                    if (start) begin
                        state        <= FETCH;
                        busy         <= 1'b1;
                        bus.blkData  <= '0;
                        slot         <= '0;
                        issued       <= 3'd1;
                        bus.bramEn   <= 1'b1;
                        bus.bramAddr <= cnt[ADDR_W-1:0];
                        cnt          <= cnt + 1'b1;
                    end
                end
                FETCH: begin
                    if (rd_pend) begin
                        bus.blkData <= place_word(bus.blkData, slot, bus.bramDout);
                        slot        <= slot + 2'd1;
                    end
                    if (issued != BLK_CNT && cnt != LAST_CNT) begin
                        bus.bramEn   <= 1'b1;
                        bus.bramAddr <= cnt[ADDR_W-1:0];
                        cnt          <= cnt + 1'b1;
                        issued       <= issued + 3'd1;
                    end else begin
                        bus.bramEn <= 1'b0;
                        state      <= WAIT;
                    end
                end
                WAIT: begin
                    if (rd_pend) begin
                        bus.blkData <= place_word(bus.blkData, slot, bus.bramDout);
                        slot        <= slot + 2'd1;
                    end
                    bus.blkValid <= 1'b1;
                    bus.blkLast  <= (cnt == LAST_CNT);
                    state        <= OUT;
                end
                OUT: begin
                    if (bus.blkReady) begin
                        bus.blkValid <= 1'b0;
                        bus.blkLast  <= 1'b0;
                        if (bus.blkLast) begin
                            state <= DONE;
                            done  <= 1'b1;
                            busy  <= 1'b0;
                        end else begin
                            // next block: clear padding and issue its first read on this edge
                            state        <= FETCH;
                            bus.blkData  <= '0;
                            slot         <= '0;
                            issued       <= 3'd1;
                            bus.bramEn   <= 1'b1;
                            bus.bramAddr <= cnt[ADDR_W-1:0];
                            cnt          <= cnt + 1'b1;
                        end
                    end
                end
                DONE: begin
                    done  <= 1'b0;
                    cnt   <= '0;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_data_bram_reader.sv
// tb/tb_data_bram_reader.sv - scoreboard bench for data_bram_reader with NDATA 8 and 17
module tb_data_bram_reader;

    typedef struct packed {
        logic         last;
        logic [127:0] data;
    } exp_t;

    logic clk;
    logic rst;
    logic start8, start17;
    logic busy8, busy17, done8, done17;
    logic ready17;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int last_hs8 = -10, last_hs17 = -10;
    int done_cnt8 = 0, done_cnt17 = 0;
    int max_addr17 = 0;

    exp_t q8[$];
    exp_t q17[$];
    exp_t e8, e17;
    logic [127:0] tab8 [2];
    logic [127:0] tab17 [5];

    data_bram_reader_if #(.ADDR_W(9)) b8 ();
    data_bram_reader_if #(.ADDR_W(9)) b17 ();

    data_bram_reader #(.NDATA(8), .ADDR_W(9)) u8 (
        .clk(clk), .rst(rst), .start(start8), .busy(busy8), .done(done8), .bus(b8.master)
    );
    data_bram_reader #(.NDATA(17), .ADDR_W(9)) u17 (
        .clk(clk), .rst(rst), .start(start17), .busy(busy17), .done(done17), .bus(b17.master)
    );

    assign b8.blkReady  = 1'b1;
    assign b17.blkReady = ready17;

    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // BRAM models: word i holds 0x1000_0000 + i, one-cycle read latency
    always @(posedge clk) if (b8.bramEn) b8.bramDout <= 32'h1000_0000 + 32'(b8.bramAddr);
    always @(posedge clk) if (b17.bramEn) b17.bramDout <= 32'h1000_0000 + 32'(b17.bramAddr);

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    always @(negedge clk) begin
        if (!rst && b8.blkValid && b8.blkReady) begin
            if (q8.size() == 0) begin
                checks++; errors++;
                $display("FAIL blk8_unexpected: got %h expected no block", b8.blkData);
            end else begin
                e8 = q8.pop_front();
                check("blk8_data", b8.blkData, e8.data);
                check("blk8_last", 128'(b8.blkLast), 128'(e8.last));
                if (e8.last) last_hs8 = cyc;
            end
        end
        if (done8) begin
            done_cnt8++;
            check("done8_timing", 128'(cyc), 128'(last_hs8 + 1));
        end
    end

    always @(negedge clk) begin
        if (!rst && b17.blkValid && b17.blkReady) begin
            if (q17.size() == 0) begin
                checks++; errors++;
                $display("FAIL blk17_unexpected: got %h expected no block", b17.blkData);
            end else begin
                e17 = q17.pop_front();
                check("blk17_data", b17.blkData, e17.data);
                check("blk17_last", 128'(b17.blkLast), 128'(e17.last));
                if (e17.last) last_hs17 = cyc;
            end
        end
        if (done17) begin
            done_cnt17++;
            check("done17_timing", 128'(cyc), 128'(last_hs17 + 1));
        end
        if (b17.bramEn && int'(b17.bramAddr) > max_addr17) max_addr17 = int'(b17.bramAddr);
    end

    task automatic push8();
        q8.push_back('{last: 1'b0, data: tab8[0]});
        q8.push_back('{last: 1'b1, data: tab8[1]});
    endtask

    task automatic push17(input int n);
        for (int i = 0; i < n; i++) q17.push_back('{last: (i == 4), data: tab17[i]});
    endtask

    task automatic wait_done(input bit is17, input int max_cyc);
        int n;
        n = 0;
        while (!(is17 ? done17 : done8) && n < max_cyc) begin
            @(negedge clk);
            n++;
        end
        if (!(is17 ? done17 : done8)) begin
            checks++; errors++;
            $display("FAIL done_timeout: got no done after %0d cycles expected done", n);
        end
    endtask

    initial begin
        tab8[0]  = 128'h10000000_10000001_10000002_10000003;
        tab8[1]  = 128'h10000004_10000005_10000006_10000007;
        tab17[0] = 128'h10000000_10000001_10000002_10000003;
        tab17[1] = 128'h10000004_10000005_10000006_10000007;
        tab17[2] = 128'h10000008_10000009_1000000a_1000000b;
        tab17[3] = 128'h1000000c_1000000d_1000000e_1000000f;
        tab17[4] = 128'h10000010_00000000_00000000_00000000;

        rst = 1'b1; start8 = 1'b0; start17 = 1'b0; ready17 = 1'b1;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        check("rst_ctl8", 128'({b8.bramEn, b8.bramAddr, b8.blkValid, b8.blkLast, busy8, done8}), 128'd0);
        check("rst_data8", b8.blkData, 128'd0);
        check("rst_ctl17", 128'({b17.bramEn, b17.bramAddr, b17.blkValid, b17.blkLast, busy17, done17}), 128'd0);
        check("rst_data17", b17.blkData, 128'd0);

        // NDATA=8, ready held high, single start pulse
        push8();
        start8 = 1'b1;
        @(posedge clk); #1;
        check("first_rd8", 128'({b8.bramEn, b8.bramAddr}), 128'({1'b1, 9'd0}));
        @(negedge clk);
        start8 = 1'b0;
        repeat (4) @(negedge clk);
        check("valid8_early", 128'(b8.blkValid), 128'd0);
        @(negedge clk);
        check("valid8_at_e5", 128'(b8.blkValid), 128'd1);
        wait_done(1'b0, 40);
        check("busy8_at_done", 128'(busy8), 128'd0);
        repeat (3) @(negedge clk);
        check("done8_count_a", 128'(done_cnt8), 128'd1);

        // NDATA=17 with 10 cycles of backpressure on the first block
        ready17 = 1'b0;
        push17(5);
        start17 = 1'b1;
        @(negedge clk);
        start17 = 1'b0;
        begin
            int n;
            logic stable;
            logic [127:0] snap;
            logic snap_last;
            n = 0;
            while (!b17.blkValid && n < 20) begin
                @(negedge clk);
                n++;
            end
            check("bp_valid_seen", 128'(b17.blkValid), 128'd1);
            snap = b17.blkData;
            snap_last = b17.blkLast;
            stable = 1'b1;
            for (int i = 0; i < 10; i++) begin
                @(negedge clk);
                if (b17.blkData !== snap || b17.blkValid !== 1'b1 ||
                    b17.blkLast !== snap_last || b17.bramEn !== 1'b0) stable = 1'b0;
            end
            check("bp_stable", 128'(stable), 128'd1);
        end
        ready17 = 1'b1;
        wait_done(1'b1, 100);
        repeat (2) @(negedge clk);
        check("done17_count_a", 128'(done_cnt17), 128'd1);
        check("max_addr17", 128'(max_addr17), 128'd16);

        // start held high: one transfer, idle gap, then a fresh transfer from address 0
        push8();
        push8();
        start8 = 1'b1;
        wait_done(1'b0, 40);
        check("held_busy_done", 128'(busy8), 128'd0);
        @(negedge clk);
        check("held_idle_gap", 128'(busy8), 128'd0);
        check("held_one_xfer", 128'(done_cnt8), 128'd2);
        @(negedge clk);
        check("held_restart", 128'({busy8, b8.bramEn, b8.bramAddr}), 128'({1'b1, 1'b1, 9'd0}));
        start8 = 1'b0;
        wait_done(1'b0, 40);
        repeat (2) @(negedge clk);
        check("done8_count_b", 128'(done_cnt8), 128'd3);

        // asynchronous reset during the third block's fetch
        push17(2);
        start17 = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start17 = 1'b0;
        repeat (12) @(posedge clk);
        #2;
        check("blk2_fetch", 128'({b17.bramEn, b17.bramAddr}), 128'({1'b1, 9'd8}));
        rst = 1'b1;
        #1;
        check("async_rst_ctl", 128'({b17.bramEn, b17.bramAddr, b17.blkValid, b17.blkLast, busy17, done17}), 128'd0);
        check("async_rst_data", b17.blkData, 128'd0);
        @(negedge clk);
        rst = 1'b0;
        repeat (3) @(negedge clk);
        check("no_done_after_rst", 128'(done_cnt17), 128'd1);
        check("q17_drained_rst", 128'(q17.size()), 128'd0);
        push17(5);
        start17 = 1'b1;
        @(posedge clk); #1;
        check("restart17_addr", 128'({b17.bramEn, b17.bramAddr}), 128'({1'b1, 9'd0}));
        @(negedge clk);
        start17 = 1'b0;
        wait_done(1'b1, 100);
        repeat (2) @(negedge clk);
        check("done17_count_b", 128'(done_cnt17), 128'd2);
        check("q8_empty", 128'(q8.size()), 128'd0);
        check("q17_empty", 128'(q17.size()), 128'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1);
    end

endmodule
